tdc_sample_accumulator: RTL and testbench

// - Downstream consumer of the tdc_delay tap vector (thermometer code, N_DELAY bits).
// - Per arm request: waits for a synchronized rising start edge, lets taps settle, captures them,

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_therm2bin.sv | 30 +++
 rtl/tdc_sample_accumulator.sv | 118 +++++++++++
 tb/tb_tdc_sample_accumulator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC types and sizing helpers. Used by tdc_delay and tdc_sample_accumulator.
package tdc_pkg;

  localparam int N_DELAY_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  // Width of a tap count that can hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a sum of 2**log2_avg tap counts.
  function automatic int acc_w(input int n, input int log2_avg);
    return cnt_w(n) + log2_avg;
  endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer-to-binary tap counter.
// When TDC_BUBBLE_FIX_EN is defined, each tap is first replaced by a 3-tap majority vote.
module tdc_therm2bin import tdc_pkg::*; #(
  parameter int N_DELAY = N_DELAY_DEF,
  parameter int CNT_W   = cnt_w(N_DELAY)
) (
  input  logic [N_DELAY-1:0] therm,
  output logic [CNT_W-1:0]   count
);

  logic [N_DELAY-1:0] fixed;

`ifdef TDC_BUBBLE_FIX_EN
  // Padding: the line is assumed to be full before tap 0 and empty past the last tap.
  logic [N_DELAY+1:0] ext;
  assign ext = {1'b0, therm, 1'b1};

  for (genvar i = 0; i < N_DELAY; i++) begin : g_maj
    assign fixed[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
  end
`else
  assign fixed = therm;
`endif

  always_comb begin
    count = '0;
    for (int i = 0; i < N_DELAY; i++) count = count + CNT_W'(fixed[i]);
  end

endmodule

// File: rtl/tdc_sample_accumulator.sv
// Averaging TDC readout: syncs start/taps, captures 2**LOG2_AVG samples per arm, returns the sum.
// Optional tap bubble correction under TDC_BUBBLE_FIX_EN (see tdc_therm2bin).
module tdc_sample_accumulator import tdc_pkg::*; #(
  parameter  int N_DELAY    = N_DELAY_DEF,
  parameter  int LOG2_AVG   = 2,
  parameter  int SETTLE_CYC = 2,
  localparam int CNT_W      = cnt_w(N_DELAY),
  localparam int ACC_W      = acc_w(N_DELAY, LOG2_AVG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DELAY-1:0] therm_in,
  input  logic               start_in,
  input  logic               arm,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic               res_sat
);

  localparam int SAMPLES  = 1 << LOG2_AVG;
  localparam int SMP_W    = LOG2_AVG + 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

  state_t state_q, state_d;

  logic               start_meta, start_sync, start_prev;
  logic               start_edge;
  logic [N_DELAY-1:0] therm_meta, therm_sync;
  logic [SETTLE_W-1:0] settle_q;
  logic [SMP_W-1:0]   smp_q;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic               sticky_q, sat_nxt;
  logic [CNT_W-1:0]   tap_cnt;
  logic               last_cap, settled;

  // Both pad inputs are asynchronous; two flops each before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
      therm_meta <= '0;
      therm_sync <= '0;
    end else begin
      start_meta <= start_in;
      start_sync <= start_meta;
      start_prev <= start_sync;
      therm_meta <= therm_in;
      therm_sync <= therm_meta;
    end
  end

  assign start_edge = start_sync & ~start_prev;

  tdc_therm2bin #(.N_DELAY(N_DELAY), .CNT_W(CNT_W)) u_therm2bin (
    .therm (therm_sync),
    .count (tap_cnt)
  );

  assign acc_nxt  = acc_q + ACC_W'(tap_cnt);
  assign sat_nxt  = sticky_q | (&therm_sync);
  assign last_cap = (smp_q == SMP_W'(SAMPLES - 1));
  assign settled  = (settle_q == SETTLE_W'(SETTLE_CYC - 1));
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arm) state_d = WAIT_EDGE;
      WAIT_EDGE: if (start_edge) state_d = SETTLE;
      SETTLE:    if (settled) state_d = CAPTURE;
      CAPTURE:   state_d = last_cap ? DONE : WAIT_EDGE;
      DONE:      if (res_valid && res_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settle_q <= '0;
    else if (state_q == SETTLE) settle_q <= settle_q + SETTLE_W'(1);
    else settle_q <= '0;
  end

  // The final capture goes straight into the output regs so the result lands as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      smp_q     <= '0;
      sticky_q  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
    end else if (state_q == CAPTURE) begin
      if (last_cap) begin
        res_data  <= acc_nxt;
        res_sat   <= sat_nxt;
        res_valid <= 1'b1;
        acc_q     <= '0;
        smp_q     <= '0;
        sticky_q  <= 1'b0;
      end else begin
        acc_q    <= acc_nxt;
        smp_q    <= smp_q + SMP_W'(1);
        sticky_q <= sat_nxt;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_sample_accumulator.sv
// Scoreboard bench for tdc_sample_accumulator (N_DELAY=32, LOG2_AVG=2, SETTLE_CYC=2).
module tb_tdc_sample_accumulator;

  localparam int N  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  therm_in = '0;
  logic          start_in = 1'b0;
  logic          arm = 1'b0;
  logic          res_ready = 1'b0;
  logic          busy, res_valid, res_sat;
  logic [AW-1:0] res_data;

  typedef struct packed {
    logic [AW-1:0] data;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  tdc_sample_accumulator #(.N_DELAY(N), .LOG2_AVG(2), .SETTLE_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .therm_in  (therm_in),
    .start_in  (start_in),
    .arm       (arm),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sat   (res_sat)
  );

  // Reference tap count: neighbourhood vote with a full line before tap 0 and empty past the end.
  function automatic int model_count(input logic [N-1:0] v);
    int c;
    int l, r;
`ifdef TDC_BUBBLE_FIX_EN
    c = 0;
    for (int i = 0; i < N; i++) begin
      l = (i == 0) ? 1 : int'(v[i-1]);
      r = (i == N - 1) ? 0 : int'(v[i+1]);
      if (l + int'(v[i]) + r >= 2) c++;
    end
`else
    c = $countones(v);
    l = 0;
    r = 0;
`endif
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [N-1:0] t);
    therm_in = t;
    start_in = 1'b1;
    tick(3);
    start_in = 1'b0;
    tick(6);
  endtask

  task automatic run_batch(input logic [N-1:0] t0, t1, t2, t3);
    exp_t e;
    e.data = AW'(model_count(t0) + model_count(t1) + model_count(t2) + model_count(t3));
    e.sat  = (&t0) | (&t1) | (&t2) | (&t3);
    sb.push_back(e);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    pulse_start(t0);
    pulse_start(t1);
    pulse_start(t2);
    pulse_start(t3);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    therm_in = 32'hDEAD_BEEF;
    start_in = 1'b1;
    arm = 1'b1;
    res_ready = 1'b1;
    tick(4);
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL reset_valid got %b want 0", res_valid); end
    nvec++; if (res_data !== '0) begin nmis++; $display("FAIL reset_data got %0d want 0", res_data); end
    nvec++; if (res_sat !== 1'b0) begin nmis++; $display("FAIL reset_sat got %b want 0", res_sat); end
    therm_in = '0;
    start_in = 1'b0;
    arm = 1'b0;
    res_ready = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
  endtask

  // Waits for a result, checks it against the scoreboard head, then handshakes it away.
  task automatic test_single_batch();
    bit   ok;
    exp_t e;
    run_batch(32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF);
    wait_valid(ok);
    e = sb.pop_front();
    nvec++; if (!ok) begin nmis++; $display("FAIL single_timeout res_valid never rose"); end
    nvec++; if (res_data !== e.data) begin nmis++; $display("FAIL single_data got %0d want %0d", res_data, e.data); end
    nvec++; if (res_sat !== e.sat) begin nmis++; $display("FAIL single_sat got %b want %b", res_sat, e.sat); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    nvec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      nmis++; $display("FAIL single_drop valid=%b busy=%b want 0 0", res_valid, busy);
    end
    tick(2);
  endtask

  task automatic test_saturation();
    bit   ok;
    exp_t e;
    run_batch(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    wait_valid(ok);
    e = sb.pop_front();
    nvec++; if (!ok) begin nmis++; $display("FAIL sat_timeout res_valid never rose"); end
    nvec++; if (res_data !== e.data) begin nmis++; $display("FAIL sat_data got %0d want %0d", res_data, e.data); end
    nvec++; if (res_sat !== e.sat) begin nmis++; $display("FAIL sat_flag got %b want %b", res_sat, e.sat); end
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    run_batch(32'h0000_0003, 32'h0000_001F, 32'h0001_FFFF, 32'h0);
    wait_valid(ok);
    e = sb.pop_front();
    nvec++; if (!ok) begin nmis++; $display("FAIL bp_timeout res_valid never rose"); end
    // Hold off the consumer while throwing arm and start edges at the block.
    for (int i = 0; i < 10; i++) begin
      arm = 1'b1;
      start_in = i[1];
      therm_in = 32'hFFFF_FFFF;
      @(negedge clk);
      nvec++; if (res_valid !== 1'b1 || busy !== 1'b1) begin
        nmis++; $display("FAIL bp_hold cyc %0d valid=%b busy=%b want 1 1", i, res_valid, busy);
      end
      nvec++; if (res_data !== e.data) begin nmis++; $display("FAIL bp_data cyc %0d got %0d want %0d", i, res_data, e.data); end
      nvec++; if (res_sat !== e.sat) begin nmis++; $display("FAIL bp_sat cyc %0d got %b want %b", i, res_sat, e.sat); end
    end
    start_in = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL bp_release_valid got %b want 0", res_valid); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL bp_release_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL bp_arm_in_handshake busy got %b want 0", busy); end
    therm_in = '0;
    tick(4);
  endtask

  task automatic test_bubble();
    bit   ok;
    exp_t e;
    run_batch(32'h0000_00F7, 32'h0000_00F7, 32'h0000_00F7, 32'h0000_00F7);
    wait_valid(ok);
    e = sb.pop_front();
    nvec++; if (!ok) begin nmis++; $display("FAIL bubble_timeout res_valid never rose"); end
    nvec++; if (res_data !== e.data) begin nmis++; $display("FAIL bubble_data got %0d want %0d", res_data, e.data); end
    nvec++; if (res_sat !== e.sat) begin nmis++; $display("FAIL bubble_sat got %b want %b", res_sat, e.sat); end
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_batch();
    bit   ok;
    exp_t e;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    pulse_start(32'h0000_00FF);
    pulse_start(32'h0000_00FF);
    rst_n = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL midrst_busy got %b want 0", busy); end
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL midrst_valid got %b want 0", res_valid); end
    nvec++; if (res_data !== '0) begin nmis++; $display("FAIL midrst_data got %0d want 0", res_data); end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    run_batch(32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F);
    wait_valid(ok);
    e = sb.pop_front();
    nvec++; if (!ok) begin nmis++; $display("FAIL midrst_timeout res_valid never rose"); end
    nvec++; if (res_data !== e.data) begin nmis++; $display("FAIL midrst_new_data got %0d want %0d", res_data, e.data); end
    nvec++; if (res_sat !== e.sat) begin nmis++; $display("FAIL midrst_new_sat got %b want %b", res_sat, e.sat); end
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_batch();
    test_saturation();
    test_backpressure();
    test_bubble();
    test_reset_mid_batch();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
